fb_scan_reader: RTL and testbench



---
 rtl/fb_scan_reader_pkg.sv | 44 ++++
 rtl/fb_scan_reader_if.sv | 32 +++
 rtl/display_timing.vh | 32 +++
 rtl/memory_sizes.vh | 14 +
 rtl/vga_timing_gen.sv | 82 ++++++++
 rtl/fb_scan_reader.sv | 124 ++++++++++++
 tb/tb_fb_scan_reader.sv | 227 ++++++++++++++++++++++
 7 files changed

// File: rtl/fb_scan_reader_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// fb_scan_reader_pkg
// Shared types, timing defaults and helpers for the framebuffer scan-out path.
// Revision: 1.0
// ============================================================================
package fb_scan_reader_pkg;
`include "display_timing.vh"
`include "memory_sizes.vh"

  localparam int DISP_ADDR_W     = `DISP_ADDR_WIDTH;
  localparam int H_ACTIVE_DEF    = `DT_H_ACTIVE;
  localparam int H_FP_DEF        = `DT_H_FP;
  localparam int H_SYNC_DEF      = `DT_H_SYNC;
  localparam int H_BP_DEF        = `DT_H_BP;
  localparam int V_ACTIVE_DEF    = `DT_V_ACTIVE;
  localparam int V_FP_DEF        = `DT_V_FP;
  localparam int V_SYNC_DEF      = `DT_V_SYNC;
  localparam int V_BP_DEF        = `DT_V_BP;
  localparam int SCALE_SHIFT_DEF = `DT_SCALE_SHIFT;
  localparam int FB_W_DEF        = `DT_FB_W;
  localparam logic SYNC_POL_DEF  = `DT_SYNC_POL;

  localparam int RGB_R_HI = `DT_R_HI;
  localparam int RGB_R_LO = `DT_R_LO;
  localparam int RGB_G_HI = `DT_G_HI;
  localparam int RGB_G_LO = `DT_G_LO;
  localparam int RGB_B_HI = `DT_B_HI;
  localparam int RGB_B_LO = `DT_B_LO;

  typedef logic [DISP_ADDR_W-1:0] disp_addr_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  function automatic int timing_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction
endpackage
`default_nettype wire

// File: rtl/fb_scan_reader_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// fb_scan_reader_if
// Framebuffer port-B read bus plus VGA output bundle of the scan reader.
// Revision: 1.0
// ============================================================================
interface fb_scan_reader_if;
  import fb_scan_reader_pkg::*;

  logic       fb_re;
  disp_addr_t fb_addr;
  logic [31:0] fb_rdata;
  logic [3:0] vga_r;
  logic [3:0] vga_g;
  logic [3:0] vga_b;
  logic       vga_hs;
  logic       vga_vs;
  logic       vga_de;
  logic       frame_tick;

  modport master (
    output fb_re, fb_addr, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de, frame_tick,
    input  fb_rdata
  );

  modport slave (
    input  fb_re, fb_addr, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de, frame_tick,
    output fb_rdata
  );
endinterface
`default_nettype wire

// File: rtl/display_timing.vh
`default_nettype none
// ============================================================================
// display_timing.vh
// VGA 640x480@60 timing defaults and framebuffer-word colour slice positions.
// Revision: 1.0
// ============================================================================
`ifndef DISPLAY_TIMING_VH
`define DISPLAY_TIMING_VH

`define DT_H_ACTIVE    640
`define DT_H_FP        16
`define DT_H_SYNC      96
`define DT_H_BP        48
`define DT_V_ACTIVE    480
`define DT_V_FP        10
`define DT_V_SYNC      2
`define DT_V_BP        33
`define DT_H_TOTAL     (`DT_H_ACTIVE + `DT_H_FP + `DT_H_SYNC + `DT_H_BP)
`define DT_V_TOTAL     (`DT_V_ACTIVE + `DT_V_FP + `DT_V_SYNC + `DT_V_BP)
`define DT_SCALE_SHIFT 2
`define DT_FB_W        160
`define DT_SYNC_POL    1'b0

`define DT_R_HI 23
`define DT_R_LO 20
`define DT_G_HI 15
`define DT_G_LO 12
`define DT_B_HI 7
`define DT_B_LO 4

`endif
`default_nettype wire

// File: rtl/memory_sizes.vh
`default_nettype none
// ============================================================================
// memory_sizes.vh
// Display framebuffer geometry shared by the write and scan-out ports.
// Revision: 1.0
// ============================================================================
`ifndef MEMORY_SIZES_VH
`define MEMORY_SIZES_VH

`define DISP_ADDR_WIDTH 15
`define DISP_WORDS      19200

`endif
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// vga_timing_gen
// Raster counters, raw sync/active flags and the start-of-vblank frame tick.
// Revision: 1.0
// ============================================================================
module vga_timing_gen
  import fb_scan_reader_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_DEF,
  parameter int   H_FP     = H_FP_DEF,
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BP     = H_BP_DEF,
  parameter int   V_ACTIVE = V_ACTIVE_DEF,
  parameter int   V_FP     = V_FP_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BP     = V_BP_DEF,
  parameter logic SYNC_POL = SYNC_POL_DEF,
  localparam int  H_TOTAL  = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int  V_TOTAL  = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int  H_W      = $clog2(H_TOTAL),
  localparam int  V_W      = $clog2(V_TOTAL)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           pix_ce,
  output logic [H_W-1:0] h_cnt_o,
  output logic [V_W-1:0] v_cnt_o,
  output logic           active_o,
  output logic           v_active_o,
  output logic           hs_o,
  output logic           vs_o,
  output logic           line_end_o,
  output logic           frame_end_o,
  output logic           frame_tick_o
);
  localparam logic [H_W-1:0] C_H_ACT    = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] C_HS_START = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] C_HS_END   = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [H_W-1:0] C_H_LAST   = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0] C_V_ACT    = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] C_V_ALAST  = V_W'(V_ACTIVE - 1);
  localparam logic [V_W-1:0] C_VS_START = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] C_VS_END   = V_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [V_W-1:0] C_V_LAST   = V_W'(V_TOTAL - 1);

  logic [H_W-1:0] h_cnt_q;
  logic [V_W-1:0] v_cnt_q;
  logic           frame_tick_q;

  assign h_cnt_o      = h_cnt_q;
  assign v_cnt_o      = v_cnt_q;
  assign v_active_o   = (v_cnt_q < C_V_ACT);
  assign active_o     = (h_cnt_q < C_H_ACT) && v_active_o;
  assign hs_o         = ((h_cnt_q >= C_HS_START) && (h_cnt_q < C_HS_END)) ? SYNC_POL : ~SYNC_POL;
  assign vs_o         = ((v_cnt_q >= C_VS_START) && (v_cnt_q < C_VS_END)) ? SYNC_POL : ~SYNC_POL;
  assign line_end_o   = (h_cnt_q == C_H_LAST);
  assign frame_end_o  = line_end_o && (v_cnt_q == C_V_LAST);
  assign frame_tick_o = frame_tick_q;

  // frame_tick is a clk-wide pulse, so it clears on every clk regardless of pix_ce
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      frame_tick_q <= 1'b0;
      if (pix_ce) begin
        if (line_end_o) begin
          h_cnt_q <= '0;
          v_cnt_q <= (v_cnt_q == C_V_LAST) ? '0 : v_cnt_q + 1'b1;
          if (v_cnt_q == C_V_ALAST) frame_tick_q <= 1'b1;
        end else begin
          h_cnt_q <= h_cnt_q + 1'b1;
        end
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/fb_scan_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// fb_scan_reader
// Raster-order framebuffer scan-out with 2^SCALE_SHIFT upscale and VGA timing.
// Revision: 1.0
// ============================================================================
module fb_scan_reader
  import fb_scan_reader_pkg::*;
#(
  parameter int   H_ACTIVE    = H_ACTIVE_DEF,
  parameter int   H_FP        = H_FP_DEF,
  parameter int   H_SYNC      = H_SYNC_DEF,
  parameter int   H_BP        = H_BP_DEF,
  parameter int   V_ACTIVE    = V_ACTIVE_DEF,
  parameter int   V_FP        = V_FP_DEF,
  parameter int   V_SYNC      = V_SYNC_DEF,
  parameter int   V_BP        = V_BP_DEF,
  parameter int   SCALE_SHIFT = SCALE_SHIFT_DEF,
  parameter int   FB_W        = FB_W_DEF,
  parameter logic SYNC_POL    = SYNC_POL_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pix_ce,
  fb_scan_reader_if.master bus
);
  localparam int H_W = $clog2(timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
  localparam int V_W = $clog2(timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP));
  localparam logic [V_W-1:0] C_ROW_MASK = V_W'((1 << SCALE_SHIFT) - 1);
  localparam disp_addr_t     C_FB_W     = DISP_ADDR_W'(FB_W);

  logic [H_W-1:0] h_cnt;
  logic [V_W-1:0] v_cnt;
  logic           active;
  logic           v_active;
  logic           hs_raw;
  logic           vs_raw;
  logic           line_end;
  logic           frame_end;
  logic           frame_tick;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .SYNC_POL (SYNC_POL)
  ) u_timing (
    .clk          (clk),
    .reset_n      (reset_n),
    .pix_ce       (pix_ce),
    .h_cnt_o      (h_cnt),
    .v_cnt_o      (v_cnt),
    .active_o     (active),
    .v_active_o   (v_active),
    .hs_o         (hs_raw),
    .vs_o         (vs_raw),
    .line_end_o   (line_end),
    .frame_end_o  (frame_end),
    .frame_tick_o (frame_tick)
  );

  disp_addr_t row_base_q;
  disp_addr_t row_base_d;
  disp_addr_t fb_addr_q;
  logic       fb_re_q;
  logic       hs_d1_q;
  logic       vs_d1_q;
  rgb12_t     rgb_q;
  logic       de_q;
  logic       hs_q;
  logic       vs_q;
  logic       unused_rdata_bits;

  // Row base advances once per replicated group of lines, replacing y*FB_W
  always_comb begin
    row_base_d = row_base_q;
    if (frame_end) begin
      row_base_d = '0;
    end else if (line_end && v_active && ((v_cnt & C_ROW_MASK) == C_ROW_MASK)) begin
      row_base_d = row_base_q + C_FB_W;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      row_base_q <= '0;
      fb_addr_q  <= '0;
      fb_re_q    <= 1'b0;
      hs_d1_q    <= ~SYNC_POL;
      vs_d1_q    <= ~SYNC_POL;
      rgb_q      <= '0;
      de_q       <= 1'b0;
      hs_q       <= ~SYNC_POL;
      vs_q       <= ~SYNC_POL;
    end else if (pix_ce) begin
      row_base_q <= row_base_d;
      fb_re_q    <= active;
      if (active) fb_addr_q <= row_base_q + DISP_ADDR_W'(h_cnt >> SCALE_SHIFT);
      hs_d1_q    <= hs_raw;
      vs_d1_q    <= vs_raw;
      // fb_re_q doubles as the stage-0 DE: it marks the word now on fb_rdata
      rgb_q      <= fb_re_q ? rgb12_t'({bus.fb_rdata[RGB_R_HI:RGB_R_LO],
                                        bus.fb_rdata[RGB_G_HI:RGB_G_LO],
                                        bus.fb_rdata[RGB_B_HI:RGB_B_LO]}) : '0;
      de_q       <= fb_re_q;
      hs_q       <= hs_d1_q;
      vs_q       <= vs_d1_q;
    end
  end

  assign unused_rdata_bits = ^{bus.fb_rdata[31:24], bus.fb_rdata[19:16],
                               bus.fb_rdata[11:8], bus.fb_rdata[3:0]};

  assign bus.fb_re      = fb_re_q;
  assign bus.fb_addr    = fb_addr_q;
  assign bus.vga_r      = rgb_q.r;
  assign bus.vga_g      = rgb_q.g;
  assign bus.vga_b      = rgb_q.b;
  assign bus.vga_de     = de_q;
  assign bus.vga_hs     = hs_q;
  assign bus.vga_vs     = vs_q;
  assign bus.frame_tick = frame_tick;
endmodule
`default_nettype wire

// File: tb/tb_fb_scan_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_fb_scan_reader
// Scoreboard bench for fb_scan_reader on a reduced raster (48x22, 8x4 words).
// Revision: 1.0
// ============================================================================
module tb_fb_scan_reader;
  localparam int HA = 32, HFP = 4, HSW = 8, HBP = 4, HT = HA + HFP + HSW + HBP;
  localparam int VA = 16, VFP = 2, VSW = 2, VBP = 2, VT = VA + VFP + VSW + VBP;
  localparam int SS = 2, FBW = HA >> SS, FRAME = HT * VT;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic pix_ce = 1'b0;
  logic force_ones = 1'b0;
  always #5 clk = ~clk;

  fb_scan_reader_if bus ();

  fb_scan_reader #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP),
    .SCALE_SHIFT (SS), .FB_W (FBW), .SYNC_POL (1'b0)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .pix_ce  (pix_ce),
    .bus     (bus)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h005A_A500;
  endfunction

  // Port-B BRAM model: one clk read latency
  always @(posedge clk) begin
    if (force_ones) bus.fb_rdata <= 32'hFFFF_FFFF;
    else if (bus.fb_re) bus.fb_rdata <= mem_word(32'(bus.fb_addr));
  end

  typedef struct {
    logic act, hs, vs, ft, frc;
    logic [31:0] addr;
    int h, v;
  } exp_t;

  exp_t q[$];
  exp_t cur_e, prev_e, disp_e;
  int n_err = 0, n_chk = 0;
  int h = 0, v = 0;
  logic [31:0] last_addr = 0;
  int de_cnt = 0, hs_cnt = 0, vs_cnt = 0, ff_cnt = 0, ft_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (model h=%0d v=%0d)", name, act, exp, h, v);
    end
  endtask

  function automatic logic [11:0] rgb_of(input exp_t e);
    logic [31:0] w;
    if (!e.act) return 12'h000;
    w = e.frc ? 32'hFFFF_FFFF : mem_word(e.addr);
    return {w[23:20], w[15:12], w[7:4]};
  endfunction

  function automatic exp_t reset_entry();
    exp_t e;
    e.act = 1'b0; e.hs = 1'b1; e.vs = 1'b1; e.ft = 1'b0; e.frc = 1'b0;
    e.addr = 0; e.h = -1; e.v = -1;
    return e;
  endfunction

  always @(negedge clk) if (bus.frame_tick === 1'b1) ft_cnt++;

  // Monitor: every pix_ce edge presents a new stage-0 request and a new pixel
  initial begin
    prev_e = reset_entry();
    disp_e = reset_entry();
    forever begin
      @(posedge clk);
      if (pix_ce && reset_n) begin
        #1;
        if (q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL sb_empty: DUT produced a pixel with no expected entry queued");
        end else begin
          cur_e = q.pop_front();
          chk("fb_re", 32'(bus.fb_re), 32'(cur_e.act));
          chk("fb_addr", 32'(bus.fb_addr), cur_e.addr);
          chk("frame_tick", 32'(bus.frame_tick), 32'(cur_e.ft));
          chk("vga_de", 32'(bus.vga_de), 32'(prev_e.act));
          chk("vga_hs", 32'(bus.vga_hs), 32'(prev_e.hs));
          chk("vga_vs", 32'(bus.vga_vs), 32'(prev_e.vs));
          chk("rgb", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'(rgb_of(prev_e)));
          if (cur_e.h == 5 && cur_e.v == 9) chk("addr_px_5_9", 32'(bus.fb_addr), 32'd17);
          if (cur_e.h == HA - 1 && cur_e.v == VA - 1) chk("addr_last_px", 32'(bus.fb_addr), 32'd31);
          if (bus.vga_de) de_cnt++;
          if (!bus.vga_hs) hs_cnt++;
          if (!bus.vga_vs) vs_cnt++;
          if ({bus.vga_r, bus.vga_g, bus.vga_b} == 12'hFFF) ff_cnt++;
          disp_e = prev_e;
          prev_e = cur_e;
        end
      end
    end
  end

  task automatic tick();
    exp_t e;
    @(negedge clk);
    e.h = h; e.v = v;
    e.act = (h < HA) && (v < VA);
    e.hs = !((h >= HA + HFP) && (h < HA + HFP + HSW));
    e.vs = !((v >= VA + VFP) && (v < VA + VFP + VSW));
    if (e.act) last_addr = 32'((v >> SS) * FBW + (h >> SS));
    e.addr = last_addr;
    e.ft = (h == HT - 1) && (v == VA - 1);
    e.frc = force_ones;
    q.push_back(e);
    if (h == HT - 1) begin
      h = 0;
      v = (v == VT - 1) ? 0 : v + 1;
    end else begin
      h++;
    end
    pix_ce = 1'b1;
    @(negedge clk);
    pix_ce = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_to(input int th, input int tv);
    int guard = 0;
    while (!(h == th && v == tv) && guard < FRAME) begin
      tick();
      guard++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    pix_ce = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_fb_re", 32'(bus.fb_re), 32'd0);
    chk("rst_fb_addr", 32'(bus.fb_addr), 32'd0);
    chk("rst_rgb", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'd0);
    chk("rst_de", 32'(bus.vga_de), 32'd0);
    chk("rst_hs", 32'(bus.vga_hs), 32'd1);
    chk("rst_vs", 32'(bus.vga_vs), 32'd1);
    chk("rst_frame_tick", 32'(bus.frame_tick), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    h = 0; v = 0; last_addr = 0;
    prev_e = reset_entry();
    disp_e = reset_entry();
  endtask

  task automatic clear_counts();
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0; ff_cnt = 0; ft_cnt = 0;
  endtask

  task automatic check_frame_counts(input string tag, input int exp_ff);
    chk({tag, "_de_ticks"}, 32'(de_cnt), 32'(HA * VA));
    chk({tag, "_hs_ticks"}, 32'(hs_cnt), 32'(HSW * VT));
    chk({tag, "_vs_ticks"}, 32'(vs_cnt), 32'(VSW * HT));
    chk({tag, "_frame_ticks"}, 32'(ft_cnt), 32'd1);
    chk({tag, "_white_px"}, 32'(ff_cnt), 32'(exp_ff));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t snap_cur, snap_disp;
    do_reset();

    // Frame 1: normal image, full raster
    clear_counts();
    repeat (FRAME) tick();
    check_frame_counts("frame1", 0);

    // Frame 2: memory returns all ones; blanking must stay black
    force_ones = 1'b1;
    clear_counts();
    repeat (FRAME) tick();
    check_frame_counts("frame2", HA * VA);
    force_ones = 1'b0;

    // Freeze mid-line for 1000 clk
    run_to(10, 3);
    snap_cur = prev_e;
    snap_disp = disp_e;
    repeat (1000) @(negedge clk);
    chk("hold_fb_re", 32'(bus.fb_re), 32'(snap_cur.act));
    chk("hold_fb_addr", 32'(bus.fb_addr), snap_cur.addr);
    chk("hold_de", 32'(bus.vga_de), 32'(snap_disp.act));
    chk("hold_hs", 32'(bus.vga_hs), 32'(snap_disp.hs));
    chk("hold_vs", 32'(bus.vga_vs), 32'(snap_disp.vs));
    chk("hold_rgb", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'(rgb_of(snap_disp)));
    chk("hold_frame_tick", 32'(bus.frame_tick), 32'd0);

    // Mid-frame reset, then one more full frame from (0,0)
    run_to(20, 10);
    do_reset();
    tick();
    chk("post_rst_fb_re", 32'(bus.fb_re), 32'd1);
    chk("post_rst_fb_addr", 32'(bus.fb_addr), 32'd0);
    clear_counts();
    repeat (FRAME - 1) tick();
    chk("frame3_de_ticks", 32'(de_cnt), 32'(HA * VA));
    chk("frame3_frame_ticks", 32'(ft_cnt), 32'd1);

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
